// File: rtl/seven_seg_decoder.sv
// Seven-segment scanner: captures a debounced 4-digit multiplexed display
// frame into packed BCD, with invalid-pattern and timeout flagging.
module seven_seg_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  hex_in,
    input  logic [1:0]  digit_sel,
    input  logic        start,
    input  logic        ready,
    output logic [15:0] bcd_out,
    output logic        valid,
    output logic        error,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0] STB = 4'(STABLE_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t        state_q, state_d;
    logic [8:0]    samp_q, samp_d;
    logic [3:0]    stab_q, stab_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    mask_q, mask_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          err_q, err_d;
    logic [3:0]    nib;
    logic          nib_bad;

    always_comb begin
        nib     = 4'hF;
        nib_bad = 1'b0;
        case (hex_in)
            7'b1000000: nib = 4'd0;
            7'b1111001: nib = 4'd1;
            7'b0100100: nib = 4'd2;
            7'b0110000: nib = 4'd3;
            7'b0011001: nib = 4'd4;
            7'b0010010: nib = 4'd5;
            7'b0000010: nib = 4'd6;
            7'b1111000: nib = 4'd7;
            7'b0000000: nib = 4'd8;
            7'b0010000: nib = 4'd9;
            default:    nib_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        stab_d  = stab_q;
        tmo_d   = tmo_q;
        mask_d  = mask_q;
        bcd_d   = bcd_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    stab_d  = '0;
                    tmo_d   = '0;
                    mask_d  = '0;
                    bcd_d   = 16'hFFFF;
                    err_d   = 1'b0;
                end
            end
            SCAN: begin
                samp_d = {digit_sel, hex_in};
                tmo_d  = tmo_q + 1'b1;
                // A zero count means no prior sample in this frame.
                if (stab_q != 4'd0 && samp_d == samp_q)
                    stab_d = (stab_q == STB) ? STB : stab_q + 4'd1;
                else
                    stab_d = 4'd1;
                if (stab_d == STB && !mask_q[digit_sel]) begin
                    mask_d[digit_sel] = 1'b1;
                    for (int k = 0; k < 4; k++)
                        if (digit_sel == 2'(k))
                            bcd_d[4*k +: 4] = nib;
                    if (nib_bad)
                        err_d = 1'b1;
                end
                // A completing capture on the timeout edge suppresses the flag.
                if (mask_q == 4'hF) begin
                    state_d = HOLD;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = HOLD;
                    if (mask_d != 4'hF)
                        err_d = 1'b1;
                end
            end
            HOLD: begin
                if (ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            samp_q  <= '0;
            stab_q  <= '0;
            tmo_q   <= '0;
            mask_q  <= '0;
            bcd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            stab_q  <= stab_d;
            tmo_q   <= tmo_d;
            mask_q  <= mask_d;
            bcd_q   <= bcd_d;
            err_q   <= err_d;
        end
    end

    assign bcd_out = bcd_q;
    assign error   = err_q;
    assign valid   = (state_q == HOLD);
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Bench for seven_seg_decoder: history-based reference model checked every
// cycle, directed frames with literal expectations, then random traffic.
module tb_seven_seg_decoder;
    localparam int ST  = 4;
    localparam int TMO = 1024;
    localparam logic [6:0] PAT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  hex_in = 7'h7F;
    logic [1:0]  digit_sel = 2'd0;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic [15:0] bcd_out;
    logic        valid;
    logic        error;
    logic        busy;

    int checks = 0;
    int errors = 0;

    seven_seg_decoder #(.STABLE_CYCLES(ST), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .hex_in(hex_in), .digit_sel(digit_sel),
        .start(start), .bcd_out(bcd_out), .valid(valid), .ready(ready),
        .error(error), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_dec(input logic [6:0] h);
        for (int i = 0; i < 10; i++)
            if (PAT[i] == h) return 4'(i);
        return 4'hF;
    endfunction

    // Model: phase 0 idle, 1 scanning, 2 holding a frame.
    int          m_ph = 0;
    int          m_cyc = 0;
    logic [15:0] m_bcd = '0;
    logic        m_err = 1'b0;
    logic [3:0]  m_cap = '0;
    logic [8:0]  hist[$];
    bit          armed = 0;

    always @(posedge clk) begin
        bit full_before;
        bit same;
        int n;
        if (reset) begin
            m_ph = 0; m_bcd = '0; m_err = 1'b0; m_cap = '0;
            hist.delete();
            armed = 1;
        end else if (m_ph == 0) begin
            if (start) begin
                m_ph = 1; m_bcd = 16'hFFFF; m_err = 1'b0; m_cap = '0;
                m_cyc = 0;
                hist.delete();
            end
        end else if (m_ph == 1) begin
            full_before = (m_cap == 4'hF);
            hist.push_back({digit_sel, hex_in});
            m_cyc++;
            n = hist.size();
            same = (n >= ST);
            if (same)
                for (int j = 1; j < ST; j++)
                    if (hist[n-1-j] != hist[n-1]) same = 0;
            if (same && !m_cap[digit_sel]) begin
                m_cap[digit_sel] = 1'b1;
                m_bcd[4*digit_sel +: 4] = ref_dec(hex_in);
                if (ref_dec(hex_in) == 4'hF) m_err = 1'b1;
            end
            if (full_before) begin
                m_ph = 2;
            end else if (m_cyc == TMO) begin
                m_ph = 2;
                if (m_cap != 4'hF) m_err = 1'b1;
            end
        end else begin
            if (ready) m_ph = 0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if ({valid, busy, error, bcd_out} !==
                {m_ph == 2, m_ph != 0, m_err, m_bcd}) begin
                errors++;
                $display("FAIL model_cmp t=%0t got v=%b b=%b e=%b bcd=%h want v=%b b=%b e=%b bcd=%h",
                         $time, valid, busy, error, bcd_out,
                         m_ph == 2, m_ph != 0, m_err, m_bcd);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic hold(input logic [1:0] s, input logic [6:0] h, input int n);
        digit_sel = s;
        hex_in = h;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic release_frame();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic top3();
        hold(2'd3, 7'b1111001, 4);
        hold(2'd2, 7'b0100100, 4);
        hold(2'd1, 7'b0110000, 4);
    endtask

    initial begin
        int cnt;
        int r;
        int len;
        repeat (2) @(negedge clk);
        chk("rst_bcd", 32'(bcd_out), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(error), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        pulse_start();
        top3();
        hold(2'd0, 7'b0011001, 4);
        chk("norm_not_yet", 32'(valid), 32'h0);
        hold(2'd0, 7'b0011001, 1);
        chk("norm_bcd", 32'(bcd_out), 32'h1234);
        chk("norm_valid", 32'(valid), 32'h1);
        chk("norm_err", 32'(error), 32'h0);

        hold(2'd0, 7'b0011001, 10);
        chk("bp_valid", 32'(valid), 32'h1);
        chk("bp_bcd", 32'(bcd_out), 32'h1234);
        release_frame();
        chk("bp_rel_valid", 32'(valid), 32'h0);
        chk("bp_rel_busy", 32'(busy), 32'h0);
        chk("bp_rel_bcd", 32'(bcd_out), 32'h1234);

        pulse_start();
        top3();
        hold(2'd0, 7'b0010010, 3);
        chk("glitch_busy", 32'(busy), 32'h1);
        hold(2'd0, 7'b0000010, 5);
        chk("glitch_bcd", 32'(bcd_out), 32'h1236);
        chk("glitch_err", 32'(error), 32'h0);
        release_frame();

        pulse_start();
        top3();
        hold(2'd0, 7'b1111111, 5);
        chk("inv_bcd", 32'(bcd_out), 32'h123F);
        chk("inv_err", 32'(error), 32'h1);
        chk("inv_valid", 32'(valid), 32'h1);
        release_frame();

        pulse_start();
        cnt = 0;
        digit_sel = 2'd0; hex_in = 7'b0011001;
        while (!valid && cnt < 1100) begin
            if (cnt == 4) begin digit_sel = 2'd1; hex_in = 7'b0110000; end
            if (cnt == 8) begin digit_sel = 2'd2; hex_in = 7'b0100100; end
            @(negedge clk);
            cnt++;
        end
        chk("tmo_cycles", 32'(cnt), 32'd1024);
        chk("tmo_err", 32'(error), 32'h1);
        chk("tmo_bcd", 32'(bcd_out), 32'hF234);
        release_frame();

        pulse_start();
        hold(2'd3, 7'b1111001, 4);
        hold(2'd2, 7'b0100100, 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rmid_bcd", 32'(bcd_out), 32'h0);
        chk("rmid_valid", 32'(valid), 32'h0);
        chk("rmid_busy", 32'(busy), 32'h0);
        hold(2'd1, 7'b0110000, 6);
        hold(2'd0, 7'b0011001, 6);
        chk("rmid_idle_busy", 32'(busy), 32'h0);
        chk("rmid_idle_bcd", 32'(bcd_out), 32'h0);

        for (int it = 0; it < 600; it++) begin
            r = $urandom_range(0, 99);
            ready = ($urandom_range(0, 3) == 0);
            reset = (r < 2);
            start = (r >= 2 && r < 20);
            digit_sel = 2'($urandom);
            if ($urandom_range(0, 5) == 0)
                hex_in = 7'($urandom);
            else
                hex_in = PAT[$urandom_range(0, 9)];
            len = $urandom_range(1, 7);
            @(negedge clk);
            reset = 1'b0;
            start = 1'b0;
            repeat (len - 1) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seven_seg_decoder.md
SEVEN_SEG_DECODER -- requirements
Module: seven_seg_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples required to capture a digit (legal range 2..15).
REQ-002 The block SHALL have parameter TIMEOUT, default 1024: maximum cycles in SCAN before a forced completion.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 hex_in  input  7  active-low segment pattern; bit0=seg a ... bit6=seg g.
REQ-007 digit_sel  input  2  index of the display digit currently present on hex_in.
REQ-008 start  input  1  one-cycle request to capture a 4-digit frame.
REQ-009 bcd_out  output  16  captured frame; nibble k (bits 4k+3:4k) = digit k.
REQ-010 valid  output  1  frame available on bcd_out.
REQ-011 ready  input  1  consumer accepts the frame when valid && ready.
REQ-012 error  output  1  frame contains an invalid pattern or timed out.
REQ-013 busy  output  1  high in SCAN and HOLD.

Function
REQ-014 The decode table (hex_in bit6..bit0 -> BCD) SHALL be: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9.
REQ-015 Any other hex_in pattern SHALL be invalid: it SHALL decode to nibble 4'hF and set error.
REQ-016 FSM states SHALL be IDLE, SCAN and HOLD.
REQ-017 IDLE: start=1 -> SCAN next cycle; this clears the captured-digit mask, stability counter, timeout counter and error, and sets bcd_out to 16'hFFFF.
REQ-018 The block SHALL register {digit_sel, hex_in} every cycle in SCAN, as follows.
  - Equal to the previous sample: stability count increments, saturating at STABLE_CYCLES.
  - Different: count reloads to 1.
REQ-019 A digit SHALL be captured on the edge at which its sample has been identical for STABLE_CYCLES consecutive edges, provided its mask bit is clear.
  - On capture: write the decoded nibble to nibble[digit_sel] and set its mask bit.
  - A pattern held STABLE_CYCLES-1 cycles and then changed SHALL NOT be captured.
REQ-020 A digit SHALL be captured at most once per frame; later stable samples for the same digit_sel SHALL be ignored.
REQ-021 Once all four mask bits are set, the FSM SHALL enter HOLD on the next edge with valid=1.
REQ-022 The timeout counter SHALL increment every SCAN cycle.
  - On reaching TIMEOUT-1 with the mask incomplete: enter HOLD with valid=1 and error=1.
  - Uncaptured nibbles SHALL remain 4'hF.
REQ-023 If capture of the last digit and the timeout occur on the same edge, the capture SHALL win: error reflects only pattern validity.
REQ-024 HOLD: bcd_out, error and valid SHALL be held stable while ready=0.
REQ-025 In HOLD, valid && ready SHALL cause IDLE on the next edge, with valid=0 and busy=0; bcd_out and error SHALL retain their values until the next start.
REQ-026 start SHALL be ignored in SCAN and HOLD.
REQ-027 Capture latency SHALL be exactly STABLE_CYCLES edges after the first sample of a new stable pattern; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-028 While reset=1 at a clock edge, the block SHALL enter IDLE with bcd_out=16'h0000, valid=0, error=0, busy=0, and all counters and the mask cleared.
REQ-029 Reset SHALL take priority over all other inputs, including start and ready.
REQ-030 Reset asserted in SCAN or HOLD SHALL abort the frame with no valid pulse; a new start SHALL be required after reset.

Verification
REQ-031 Normal frame: after reset, pulse start, then hold each pattern 4 cycles: sel3=1111001, sel2=0100100, sel1=0110000, sel0=0011001.
  -> bcd_out=16'h1234, valid=1, error=0 one edge after the last capture.
REQ-032 Glitch rejection: sel0=0010010 for 3 cycles, then sel0=0000010 for 4 cycles.
  -> nibble0=6, never 5; busy stays 1 until all digits are captured.
REQ-033 Invalid pattern: sel0=1111111 stable 4 cycles, other digits valid.
  -> bcd_out[3:0]=4'hF, error=1, valid=1.
REQ-034 Timeout: pulse start, capture only digits 0-2.
  -> valid=1 and error=1 exactly 1024 cycles after entering SCAN; bcd_out[15:12]=4'hF.
REQ-035 Backpressure: in HOLD, ready=0 for 10 cycles, then ready=1 for 1 cycle.
  -> valid and bcd_out constant for those 10 cycles; valid=0 and busy=0 on the next edge.
REQ-036 Reset mid-SCAN: assert reset after two captures.
  -> bcd_out=16'h0000, valid=0, busy=0; held start-less stimulus produces no capture.
